// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding instruction fetch FSM with redirect, stall hold and ack-timeout.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_read_enable,
    output logic [31:0] o_address,
    input  logic        i_ack,
    input  logic [31:0] i_instr,
    output logic [31:0] o_instr_out,
    output logic [31:0] o_pc_out,
    output logic        o_valid,
    output logic        o_busy,
    output logic        o_error
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

    logic [1:0]    r_state, w_state_nx;
    logic [31:0]   r_pc, w_pc_nx;
    logic [31:0]   r_addr;
    logic [31:0]   r_instr_out;
    logic [31:0]   r_pc_out;
    logic          r_valid, w_valid_nx;
    logic          r_error, w_error_nx;
    logic          r_discard, w_discard_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic          w_capture;
    logic          w_fetch;
    logic [31:0]   w_rpc;

    assign w_fetch = i_enable && !r_error;
    assign w_rpc   = {i_redirect_pc[31:2], 2'b00};

    always_comb begin
        w_state_nx   = r_state;
        w_pc_nx      = r_pc;
        w_valid_nx   = r_valid;
        w_error_nx   = r_error;
        w_discard_nx = r_discard;
        w_cnt_nx     = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_redirect) w_pc_nx = w_rpc;
                if (w_fetch) w_state_nx = REQ;
            end
            REQ: begin
                w_state_nx = WAIT;
                w_cnt_nx   = '0;
                if (i_redirect) begin
                    w_pc_nx      = w_rpc;
                    w_discard_nx = 1'b1;
                end
            end
            WAIT: begin
                if (i_redirect) begin
                    w_pc_nx      = w_rpc;
                    w_discard_nx = 1'b1;
                end
                // A redirected transaction still has to retire its ack before refetching.
                if (i_ack) begin
                    if (i_redirect || r_discard) begin
                        w_discard_nx = 1'b0;
                        w_state_nx   = REQ;
                    end else begin
                        w_capture  = 1'b1;
                        w_pc_nx    = r_pc + 32'd4;
                        w_valid_nx = 1'b1;
                        w_state_nx = HOLD;
                    end
                end else if (r_cnt == LAST) begin
                    w_error_nx   = 1'b1;
                    w_discard_nx = 1'b0;
                    w_state_nx   = IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (i_redirect || !i_stall) begin
                    w_valid_nx = 1'b0;
                    w_state_nx = w_fetch ? REQ : IDLE;
                    if (i_redirect) w_pc_nx = w_rpc;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_addr      <= RESET_PC;
            r_instr_out <= '0;
            r_pc_out    <= '0;
            r_valid     <= 1'b0;
            r_error     <= 1'b0;
            r_discard   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_pc      <= w_pc_nx;
            r_valid   <= w_valid_nx;
            r_error   <= w_error_nx;
            r_discard <= w_discard_nx;
            r_cnt     <= w_cnt_nx;
            if (w_state_nx == REQ) r_addr <= w_pc_nx;
            if (w_capture) begin
                r_instr_out <= i_instr;
                r_pc_out    <= r_addr;
            end
        end
    end

    assign o_read_enable = r_state == REQ;
    assign o_address     = r_addr;
    assign o_instr_out   = r_instr_out;
    assign o_pc_out      = r_pc_out;
    assign o_valid       = r_valid;
    assign o_busy        = (r_state == REQ) || (r_state == WAIT);
    assign o_error       = r_error;
endmodule
